// File: rtl/mem_check_pkg.sv
// mem_check_pkg: shared FSM state type and default sizing for the memory result checker.
package mem_check_pkg;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_DEPTH     = 36;
    localparam int DEF_MAX_CYCLE = 1000;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SWEEP, S_PASS, S_FAIL, S_TIMEOUT} state_e;
endpackage

// File: rtl/mem_result_checker_if.sv
// mem_result_checker_if: checker control/memory bus; CHECKER_FIRST_ERR_EN adds first-mismatch outputs.
interface mem_result_checker_if
    import mem_check_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    localparam int IDX_W = $clog2(DEPTH);
    logic              start;
    logic [ADDR_W-1:0] eof_addr;
    logic [ADDR_W-1:0] mem_addr_I;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [WIDTH-1:0]  rd_data_dut;
    logic [WIDTH-1:0]  rd_data_ans;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  cyc_cnt;
`ifdef CHECKER_FIRST_ERR_EN
    logic [IDX_W-1:0]  first_err_idx;
    logic [WIDTH-1:0]  first_err_exp;
    logic [WIDTH-1:0]  first_err_act;
    modport master (
        output start, eof_addr, mem_addr_I, rd_data_dut, rd_data_ans,
        input  rd_en, rd_idx, busy, done, pass, timeout, err_cnt, cyc_cnt,
        input  first_err_idx, first_err_exp, first_err_act
    );
    modport slave (
        input  start, eof_addr, mem_addr_I, rd_data_dut, rd_data_ans,
        output rd_en, rd_idx, busy, done, pass, timeout, err_cnt, cyc_cnt,
        output first_err_idx, first_err_exp, first_err_act
    );
`else
    modport master (
        output start, eof_addr, mem_addr_I, rd_data_dut, rd_data_ans,
        input  rd_en, rd_idx, busy, done, pass, timeout, err_cnt, cyc_cnt
    );
    modport slave (
        input  start, eof_addr, mem_addr_I, rd_data_dut, rd_data_ans,
        output rd_en, rd_idx, busy, done, pass, timeout, err_cnt, cyc_cnt
    );
`endif
endinterface

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/mem_result_checker.sv
// mem_result_checker: waits for the fetch address to hit eof_addr, then compares DUT and answer memories.
// Define CHECKER_FIRST_ERR_EN to capture index and words of the first mismatch of a sweep.
module mem_result_checker
    import mem_check_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = 32,
    parameter int MAX_CYCLE = DEF_MAX_CYCLE,
    parameter int CNT_W     = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_result_checker_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] eof_q, eof_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              cmp_q, cmp_d;
    logic [WIDTH-1:0]  dut_w, ans_w;
    logic [IDX_W-1:0]  rd_idx;
    logic [CNT_W-1:0]  cyc_cnt, err_cnt;
    logic              arm, rd_en, mismatch, last_cmp;

    // cnt_q walks 0..DEPTH in SWEEP: reads on 0..DEPTH-1, the final step only compares
    always_comb begin
        dut_w    = bus.rd_data_dut;
        ans_w    = bus.rd_data_ans;
        arm      = bus.start && state_q != S_RUN && state_q != S_SWEEP;
        rd_en    = state_q == S_SWEEP && cnt_q < CW'(DEPTH);
        rd_idx   = rd_en ? cnt_q[IDX_W-1:0] : idx_q;
        mismatch = cmp_q && dut_w != ans_w;
        last_cmp = state_q == S_SWEEP && cnt_q == CW'(DEPTH);
        eof_d    = arm ? bus.eof_addr : eof_q;
        cnt_d    = state_q == S_SWEEP ? cnt_q + CW'(1) : '0;
        idx_d    = rd_idx;
        cmp_d    = rd_en;
        state_d  = arm ? S_RUN
                 : state_q == S_RUN ? (bus.mem_addr_I == eof_q ? S_SWEEP
                                       : cyc_cnt == CNT_W'(MAX_CYCLE - 1) ? S_TIMEOUT : S_RUN)
                 : last_cmp ? ((err_cnt == '0 && !mismatch) ? S_PASS : S_FAIL)
                 : state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            eof_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            eof_q   <= eof_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cmp_q   <= cmp_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cyc (
        .clk(clk), .rst_n(rst_n), .clr(arm), .inc(state_q == S_RUN), .cnt(cyc_cnt)
    );
    sat_counter #(.W(CNT_W)) u_err (
        .clk(clk), .rst_n(rst_n), .clr(arm), .inc(mismatch), .cnt(err_cnt)
    );

    assign bus.rd_en   = rd_en;
    assign bus.rd_idx  = rd_idx;
    assign bus.busy    = state_q == S_RUN || state_q == S_SWEEP;
    assign bus.done    = state_q == S_PASS || state_q == S_FAIL || state_q == S_TIMEOUT;
    assign bus.pass    = state_q == S_PASS;
    assign bus.timeout = state_q == S_TIMEOUT;
    assign bus.err_cnt = err_cnt;
    assign bus.cyc_cnt = cyc_cnt;

`ifdef CHECKER_FIRST_ERR_EN
    logic             fe_vld_q, fe_vld_d, fe_cap;
    logic [IDX_W-1:0] fe_idx_q, fe_idx_d;
    logic [WIDTH-1:0] fe_exp_q, fe_exp_d, fe_act_q, fe_act_d;

    // idx_q still holds the index of the read being compared this cycle
    always_comb begin
        fe_cap   = mismatch && !fe_vld_q;
        fe_vld_d = !arm && (fe_vld_q || mismatch);
        fe_idx_d = arm ? '0 : fe_cap ? idx_q : fe_idx_q;
        fe_exp_d = arm ? '0 : fe_cap ? ans_w : fe_exp_q;
        fe_act_d = arm ? '0 : fe_cap ? dut_w : fe_act_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fe_vld_q <= 1'b0;
            fe_idx_q <= '0;
            fe_exp_q <= '0;
            fe_act_q <= '0;
        end else begin
            fe_vld_q <= fe_vld_d;
            fe_idx_q <= fe_idx_d;
            fe_exp_q <= fe_exp_d;
            fe_act_q <= fe_act_d;
        end
    end

    assign bus.first_err_idx = fe_idx_q;
    assign bus.first_err_exp = fe_exp_q;
    assign bus.first_err_act = fe_act_q;
`endif
endmodule

// File: tb/tb_mem_result_checker.sv
// tb_mem_result_checker: directed + randomized runs of the checker against a behavioural model.
module tb_mem_result_checker;
    localparam int WIDTH = 32, DEPTH = 36, ADDR_W = 32, MAX_CYCLE = 100, CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [WIDTH-1:0] dut_mem [DEPTH];
    logic [WIDTH-1:0] ans_mem [DEPTH];
    bit   err_at [DEPTH];
    int   n_checks = 0, n_fail = 0;
    int   rd_pulses, done_at, e;
    bit   order_ok;

    always #5 clk = ~clk;

    mem_result_checker_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    mem_result_checker #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_CYCLE(MAX_CYCLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // both memories answer one cycle after the read strobe
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_dut <= dut_mem[bus.rd_idx];
            bus.rd_data_ans <= ans_mem[bus.rd_idx];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_err();
        for (int i = 0; i < DEPTH; i++) err_at[i] = 1'b0;
    endtask

    task automatic load();
        for (int i = 0; i < DEPTH; i++) begin
            ans_mem[i] = WIDTH'($urandom);
            dut_mem[i] = err_at[i] ? ans_mem[i] ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1)) : ans_mem[i];
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " done"}, bus.done, 0);
        check({tag, " pass"}, bus.pass, 0);
        check({tag, " timeout"}, bus.timeout, 0);
        check({tag, " rd_en"}, bus.rd_en, 0);
        check({tag, " rd_idx"}, bus.rd_idx, 0);
        check({tag, " err_cnt"}, bus.err_cnt, 0);
        check({tag, " cyc_cnt"}, bus.cyc_cnt, 0);
`ifdef CHECKER_FIRST_ERR_EN
        check({tag, " first_err_idx"}, bus.first_err_idx, 0);
        check({tag, " first_err_exp"}, bus.first_err_exp, 0);
        check({tag, " first_err_act"}, bus.first_err_act, 0);
`endif
    endtask

    // eof_cycle: RUN cycle (1-based) presenting the eof address, 0 = never
    task automatic run(input int eof_cycle, input int ign_at, input int rst_idx);
        logic [ADDR_W-1:0] eof;
        eof       = ADDR_W'($urandom);
        done_at   = 0;
        rd_pulses = 0;
        order_ok  = 1'b1;
        load();
        @(negedge clk);
        bus.start      = 1'b1;
        bus.eof_addr   = eof;
        bus.mem_addr_I = eof + 1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.eof_addr = ~eof;
        check("arm busy", bus.busy, 1);
        check("arm done", bus.done, 0);
        check("arm err_cnt", bus.err_cnt, 0);
        check("arm cyc_cnt", bus.cyc_cnt, 0);
        for (int n = 1; n <= 400; n++) begin
            if (bus.done) begin
                done_at = n;
                break;
            end
            if (bus.rd_en) begin
                if (int'(bus.rd_idx) != rd_pulses) order_ok = 1'b0;
                if (int'(bus.rd_idx) == rst_idx) begin
                    rst_n = 1'b0;
                    break;
                end
                rd_pulses++;
            end
            bus.mem_addr_I = (n == eof_cycle) ? eof : eof + ADDR_W'(4 * n);
            bus.start      = n == ign_at;
            bus.eof_addr   = (n == ign_at) ? eof + 8 : ~eof;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic verify(input string tag, input int eof_cycle);
        int exp_err = 0;
        int first   = -1;
        bit tmo     = eof_cycle <= 0 || eof_cycle > MAX_CYCLE;
        for (int i = 0; i < DEPTH; i++) begin
            if (err_at[i]) begin
                exp_err++;
                if (first < 0) first = i;
            end
        end
        check({tag, " done_at"}, done_at, tmo ? MAX_CYCLE + 1 : eof_cycle + DEPTH + 2);
        check({tag, " pass"}, bus.pass, !tmo && exp_err == 0);
        check({tag, " timeout"}, bus.timeout, tmo);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " rd_en"}, bus.rd_en, 0);
        check({tag, " err_cnt"}, bus.err_cnt, tmo ? 0 : exp_err);
        check({tag, " cyc_cnt"}, bus.cyc_cnt, tmo ? MAX_CYCLE : eof_cycle);
        check({tag, " rd_pulses"}, rd_pulses, tmo ? 0 : DEPTH);
        check({tag, " rd_order"}, order_ok, 1);
        if (!tmo) check({tag, " rd_idx_hold"}, bus.rd_idx, DEPTH - 1);
`ifdef CHECKER_FIRST_ERR_EN
        check({tag, " first_err_idx"}, bus.first_err_idx, (!tmo && first >= 0) ? first : 0);
        check({tag, " first_err_exp"}, bus.first_err_exp, (!tmo && first >= 0) ? ans_mem[first] : 0);
        check({tag, " first_err_act"}, bus.first_err_act, (!tmo && first >= 0) ? dut_mem[first] : 0);
`endif
        repeat (3) @(negedge clk);
        check({tag, " sticky done"}, bus.done, 1);
        check({tag, " sticky pass"}, bus.pass, !tmo && exp_err == 0);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.eof_addr    = '0;
        bus.mem_addr_I  = '0;
        bus.rd_data_dut = '0;
        bus.rd_data_ans = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        clear_err();
        run(50, 0, -1);
        verify("identical", 50);

        err_at[3]  = 1'b1;
        err_at[20] = 1'b1;
        e = $urandom_range(5, 90);
        run(e, 0, -1);
        verify("two_err", e);

        clear_err();
        err_at[DEPTH - 1] = 1'b1;
        run(30, 10, -1);
        verify("last_word_ignored_start", 30);

        clear_err();
        err_at[0] = 1'b1;
        run(1, 0, -1);
        verify("first_word_eof1", 1);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) err_at[i] = $urandom_range(0, 7) == 0;
            e = $urandom_range(1, MAX_CYCLE);
            run(e, 0, -1);
            verify($sformatf("random%0d", k), e);
        end

        clear_err();
        run(0, 0, -1);
        verify("timeout", 0);

        run(MAX_CYCLE, 0, -1);
        verify("eof_at_limit", MAX_CYCLE);

        err_at[9]  = 1'b1;
        err_at[10] = 1'b1;
        run(20, 0, 10);
        @(negedge clk);
        check_idle("mid_sweep_reset");
        rst_n = 1'b1;
        clear_err();
        run(20, 0, -1);
        verify("after_reset", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
